bnn_conv_pool_layer: RTL and testbench

- Parametrised binary-convolution layer: 3x3 XNOR-popcount convolution over an IN_DIM x IN_DIM x IN_CH binary feature map, per-filter batch-norm threshold, optional 2x2 max-pool.
- Successor to the fixed 14x14x8 / 4-filter layer-two block.
- New relative to that block: full per-channel weights, runtime threshold port, start/busy/done handshake, registered output, and one conv window evaluated per cycle.
- Sits between the preceding layer's output register and the dense/classifier stage; the top-level FSM drives it.

---
 rtl/bnn_pkg.sv | 27 ++
 rtl/bnn_popcount.sv | 28 ++
 rtl/bnn_conv_pool_layer.sv | 129 ++++++++++++
 tb/tb_bnn_conv_pool_layer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared encodings and flat-vector index helpers for the binary conv/pool layer.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic int cnt_width(input int n_bits);
        return $clog2(n_bits + 1);
    endfunction

    function automatic int pix_idx(input int r, input int c, input int ch,
                                   input int dim, input int n_ch);
        return (r * dim + c) * n_ch + ch;
    endfunction

    function automatic int wt_idx(input int f, input int kr, input int kc, input int n_ch);
        return (f * 9 + kr * 3 + kc) * n_ch;
    endfunction

    function automatic int out_idx(input int f, input int r, input int c, input int out_dim);
        return f * out_dim * out_dim + r * out_dim + c;
    endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational population count built as a recursive balanced adder tree.
module bnn_popcount #(
    parameter int N_BITS = 72
) (
    input  logic [N_BITS-1:0]             vec,
    output logic [$clog2(N_BITS+1)-1:0]   count
);

    localparam int CW = $clog2(N_BITS + 1);

    generate
        if (N_BITS == 1) begin : g_leaf
            assign count = vec;
        end else begin : g_split
            localparam int LO = N_BITS / 2;
            localparam int HI = N_BITS - LO;

            logic [$clog2(LO+1)-1:0] lo_cnt;
            logic [$clog2(HI+1)-1:0] hi_cnt;

            bnn_popcount #(.N_BITS(LO)) u_lo (.vec(vec[LO-1:0]),      .count(lo_cnt));
            bnn_popcount #(.N_BITS(HI)) u_hi (.vec(vec[N_BITS-1:LO]), .count(hi_cnt));

            assign count = CW'(lo_cnt) + CW'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/bnn_conv_pool_layer.sv
// Binary 3x3 XNOR-popcount convolution with per-filter threshold and optional
// 2x2 max-pool; evaluates one conv window per cycle.
module bnn_conv_pool_layer
    import bnn_pkg::*;
#(
    parameter int IN_DIM  = 14,
    parameter int IN_CH   = 8,
    parameter int N_FILT  = 4,
    parameter int POOL_EN = 1,
    parameter int CNT_W   = cnt_width(9 * IN_CH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [IN_DIM*IN_DIM*IN_CH-1:0]        pixels,
    input  logic [N_FILT*9*IN_CH-1:0]             weights,
    input  logic [N_FILT*CNT_W-1:0]               thresholds,
    output logic                                  busy,
    output logic                                  done,
    output logic [N_FILT*((POOL_EN != 0) ? IN_DIM/2 : IN_DIM)*((POOL_EN != 0) ? IN_DIM/2 : IN_DIM)-1:0] layer_out
);

    localparam int OUT_DIM = (POOL_EN != 0) ? IN_DIM / 2 : IN_DIM;
    localparam int WIN     = 9 * IN_CH;
    localparam int F_W     = (N_FILT > 1) ? $clog2(N_FILT) : 1;
    localparam int D_W     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [F_W-1:0] F_MAX = F_W'(N_FILT - 1);
    localparam logic [D_W-1:0] D_MAX = D_W'(OUT_DIM - 1);
    localparam logic [1:0]     Q_MAX = (POOL_EN != 0) ? 2'd3 : 2'd0;

    state_t state, state_next;

    logic [F_W-1:0]          f_cnt;
    logic [D_W-1:0]          r_cnt, c_cnt;
    logic [1:0]              q_cnt;
    logic                    pool_acc;
    logic [N_FILT*WIN-1:0]   weights_reg;
    logic [N_FILT*CNT_W-1:0] thresholds_reg;
    logic [WIN-1:0]          window, match;
    logic [CNT_W-1:0]        count, thr;
    logic                    hit, q_last, c_last, r_last, f_last, pass_last;
    int                      centre_r, centre_c;

    assign q_last    = (q_cnt == Q_MAX);
    assign c_last    = (c_cnt == D_MAX);
    assign r_last    = (r_cnt == D_MAX);
    assign f_last    = (f_cnt == F_MAX);
    assign pass_last = q_last & c_last & r_last & f_last;

    // Window gather: neighbours outside the map read as zero pixels.
    always_comb begin
        centre_r = (POOL_EN != 0) ? 2 * int'(r_cnt) + int'(q_cnt[1]) : int'(r_cnt);
        centre_c = (POOL_EN != 0) ? 2 * int'(c_cnt) + int'(q_cnt[0]) : int'(c_cnt);
        window   = '0;
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                if ((centre_r + kr - 1 >= 0) && (centre_r + kr - 1 < IN_DIM) &&
                    (centre_c + kc - 1 >= 0) && (centre_c + kc - 1 < IN_DIM)) begin
                    window[(kr*3+kc)*IN_CH +: IN_CH] =
                        pixels[pix_idx(centre_r + kr - 1, centre_c + kc - 1, 0, IN_DIM, IN_CH) +: IN_CH];
                end
            end
        end
        match = ~(window ^ weights_reg[wt_idx(int'(f_cnt), 0, 0, IN_CH) +: WIN]);
        thr   = thresholds_reg[int'(f_cnt)*CNT_W +: CNT_W];
    end

    bnn_popcount #(.N_BITS(WIN)) u_popcount (.vec(match), .count(count));

    assign hit = (count >= thr);

    // start is taken only in IDLE; busy covers exactly the RUN cycles and
    // done is a single-cycle pulse in FINISH, after which layer_out is final.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (pass_last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == FINISH);

    always_ff @(posedge clk) begin
        if (rst) begin
            f_cnt          <= '0;
            r_cnt          <= '0;
            c_cnt          <= '0;
            q_cnt          <= '0;
            pool_acc       <= 1'b0;
            layer_out      <= '0;
            weights_reg    <= '0;
            thresholds_reg <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                weights_reg    <= weights;
                thresholds_reg <= thresholds;
                layer_out      <= '0;
                f_cnt          <= '0;
                r_cnt          <= '0;
                c_cnt          <= '0;
                q_cnt          <= '0;
                pool_acc       <= 1'b0;
            end
        end else if (state == RUN) begin
            if (q_last) begin
                layer_out[out_idx(int'(f_cnt), int'(r_cnt), int'(c_cnt), OUT_DIM)] <= pool_acc | hit;
                pool_acc <= 1'b0;
                c_cnt    <= c_last ? '0 : c_cnt + D_W'(1);
                if (c_last) begin
                    r_cnt <= r_last ? '0 : r_cnt + D_W'(1);
                    if (r_last) f_cnt <= f_last ? '0 : f_cnt + F_W'(1);
                end
            end else begin
                pool_acc <= pool_acc | hit;
            end
            q_cnt <= q_last ? 2'd0 : q_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_bnn_conv_pool_layer.sv
// Directed bench for the binary conv/pool layer: default pooled instance plus a
// small unpooled instance checked against a straightforward software reference.
module tb_bnn_conv_pool_layer;

    logic clk = 1'b0;
    logic rst;

    logic          start_a;
    logic [1567:0] pix_a;
    logic [287:0]  wt_a;
    logic [27:0]   thr_a;
    logic          busy_a, done_a;
    logic [195:0]  out_a;

    logic          start_b;
    logic [31:0]   pix_b;
    logic [35:0]   wt_b;
    logic [9:0]    thr_b;
    logic          busy_b, done_b;
    logic [31:0]   out_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bnn_conv_pool_layer u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pixels(pix_a), .weights(wt_a),
        .thresholds(thr_a), .busy(busy_a), .done(done_a), .layer_out(out_a)
    );

    bnn_conv_pool_layer #(.IN_DIM(4), .IN_CH(2), .N_FILT(2), .POOL_EN(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pixels(pix_b), .weights(wt_b),
        .thresholds(thr_b), .busy(busy_b), .done(done_b), .layer_out(out_b)
    );

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: for every output, OR the thresholded conv results over its pool block.
    function automatic logic [255:0] ref_layer(input logic [1567:0] pix, input logic [287:0] wt,
                                               input logic [27:0] thr, input int dim, input int nch,
                                               input int nf, input int pool, input int cw);
        logic [255:0] res;
        int od, ps, y, x, yy, xx, cnt, t;
        logic p, bit_o;
        res = '0;
        ps  = (pool != 0) ? 2 : 1;
        od  = dim / ps;
        for (int f = 0; f < nf; f++) begin
            t = 0;
            for (int b = 0; b < cw; b++) t[b] = thr[f*cw+b];
            for (int r = 0; r < od; r++) begin
                for (int c = 0; c < od; c++) begin
                    bit_o = 1'b0;
                    for (int dy = 0; dy < ps; dy++) begin
                        for (int dx = 0; dx < ps; dx++) begin
                            y = r * ps + dy;
                            x = c * ps + dx;
                            cnt = 0;
                            for (int kr = 0; kr < 3; kr++) begin
                                for (int kc = 0; kc < 3; kc++) begin
                                    yy = y + kr - 1;
                                    xx = x + kc - 1;
                                    for (int ch = 0; ch < nch; ch++) begin
                                        p = 1'b0;
                                        if (yy >= 0 && yy < dim && xx >= 0 && xx < dim)
                                            p = pix[(yy*dim+xx)*nch+ch];
                                        if (p == wt[(f*9+kr*3+kc)*nch+ch]) cnt++;
                                    end
                                end
                            end
                            if (cnt >= t) bit_o = 1'b1;
                        end
                    end
                    res[(f*od+r)*od+c] = bit_o;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [255:0] ref_b();
        logic [1567:0] p;
        logic [287:0]  w;
        logic [27:0]   t;
        p = '0; w = '0; t = '0;
        p[31:0] = pix_b;
        w[35:0] = wt_b;
        t[9:0]  = thr_b;
        return ref_layer(p, w, t, 4, 2, 2, 0, 5);
    endfunction

    task automatic run_a(output int cyc);
        @(negedge clk);
        start_a = 1'b1;
        cyc = 1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 2;
        while (!done_a && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_b(output int cyc);
        @(negedge clk);
        start_b = 1'b1;
        cyc = 1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 2;
        while (!done_b && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic rand_a();
        for (int i = 0; i < 49; i++) pix_a[i*32 +: 32] = $urandom();
        for (int i = 0; i < 9; i++)  wt_a[i*32 +: 32]  = $urandom();
        for (int f = 0; f < 4; f++)  thr_a[f*7 +: 7]   = 7'($urandom_range(20, 50));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, busy_cnt, done_cnt, done_cyc;
        logic [255:0] exp_v;
        logic [1567:0] sv_pix;
        logic [287:0]  sv_wt;
        logic [27:0]   sv_thr;

        rst = 1'b1;
        start_a = 1'b0; pix_a = '0; wt_a = '0; thr_a = '0;
        start_b = 1'b0; pix_b = '0; wt_b = '0; thr_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset, no start
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_val("idle_busy", 256'(busy_a), 256'(0));
            check_val("idle_done", 256'(done_a), 256'(0));
            check_val("idle_out",  256'(out_a),  256'(0));
        end

        // Latency / handshake with an ignored second start and mid-pass input changes
        rand_a();
        sv_pix = pix_a; sv_wt = wt_a; sv_thr = thr_a;
        @(negedge clk);
        start_a = 1'b1;
        cyc = 1; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
        while (cyc < 900) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2)   start_a = 1'b0;
            if (cyc == 100) start_a = 1'b1;
            if (cyc == 101) start_a = 1'b0;
            if (cyc == 200) begin wt_a = ~wt_a; thr_a = ~thr_a; end
            if (busy_a) busy_cnt++;
            if (done_a) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
        end
        check_val("lat_busy_cycles", 256'(busy_cnt), 256'(784));
        check_val("lat_done_pulses", 256'(done_cnt), 256'(1));
        check_val("lat_done_cycle",  256'(done_cyc), 256'(786));
        check_val("lat_out_model",   256'(out_a), ref_layer(sv_pix, sv_wt, sv_thr, 14, 8, 4, 1, 7));

        // All-ones pixels, zero weights: only padded neighbours match
        pix_a = '1;
        wt_a  = '0;
        thr_a = {7'd37, 7'd35, 7'd42, 7'd41};
        run_a(cyc);
        check_val("ones_latency", 256'(cyc), 256'(786));
        exp_v = '0;
        for (int f = 2; f < 4; f++) begin
            exp_v[f*49 + 0*7 + 0] = 1'b1;
            exp_v[f*49 + 0*7 + 6] = 1'b1;
            exp_v[f*49 + 6*7 + 0] = 1'b1;
            exp_v[f*49 + 6*7 + 6] = 1'b1;
        end
        check_val("ones_out_hand",  256'(out_a), exp_v);
        check_val("ones_out_model", 256'(out_a), ref_layer(pix_a, wt_a, thr_a, 14, 8, 4, 1, 7));
        @(negedge clk);
        check_val("ones_out_hold", 256'(out_a), exp_v);

        // Max-pool OR around a single set pixel at (5,8)
        pix_a = '0;
        pix_a[(5*14+8)*8 +: 8] = 8'hFF;
        wt_a  = '1;
        thr_a = {4{7'd1}};
        run_a(cyc);
        check_val("pool_latency", 256'(cyc), 256'(786));
        exp_v = '0;
        for (int f = 0; f < 4; f++)
            for (int r = 2; r < 4; r++)
                for (int c = 3; c < 5; c++)
                    exp_v[f*49 + r*7 + c] = 1'b1;
        check_val("pool_out_hand", 256'(out_a), exp_v);

        // Reset in the middle of a pass
        rand_a();
        @(negedge clk);
        start_a = 1'b1;
        cyc = 1;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) start_a = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_busy", 256'(busy_a), 256'(0));
        check_val("mid_rst_out",  256'(out_a),  256'(0));
        check_val("mid_rst_done", 256'(done_a), 256'(0));
        done_cnt = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (done_a || busy_a) done_cnt++;
        end
        check_val("mid_rst_quiet", 256'(done_cnt), 256'(0));
        pix_a = '0;
        pix_a[(5*14+8)*8 +: 8] = 8'hFF;
        wt_a  = '1;
        thr_a = {4{7'd1}};
        run_a(cyc);
        check_val("post_rst_latency", 256'(cyc), 256'(786));
        check_val("post_rst_out",     256'(out_a), exp_v);

        // Small unpooled instance: threshold boundaries
        pix_b = $urandom();
        wt_b  = 36'({$urandom(), $urandom()});
        thr_b = {5'd0, 5'd0};
        run_b(cyc);
        check_val("b_thr0_latency", 256'(cyc), 256'(34));
        check_val("b_thr0_out", 256'(out_b), 256'(32'hFFFF_FFFF));
        thr_b = {5'd19, 5'd19};
        run_b(cyc);
        check_val("b_thr19_out", 256'(out_b), 256'(0));
        thr_b = {5'd19, 5'd0};
        run_b(cyc);
        check_val("b_thr_mix_out", 256'(out_b), 256'(32'h0000_FFFF));

        // Small unpooled instance: random passes against the reference
        for (int n = 0; n < 200; n++) begin
            pix_b = $urandom();
            wt_b  = 36'({$urandom(), $urandom()});
            thr_b = {5'($urandom_range(0, 19)), 5'($urandom_range(0, 19))};
            run_b(cyc);
            check_val("b_rand_latency", 256'(cyc), 256'(34));
            check_val("b_rand_out", 256'(out_b), ref_b());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
